// File: rtl/dcache_wb_lru.sv
// Set-associative, write-back, write-allocate data cache with LRU replacement.
// Serves MEM-stage loads/stores; stalls the pipeline through `miss` while a
// line is written back and/or refilled over a line-wide req/gnt memory port.
// Memory port handshake: mem_rd_req / mem_wr_req rise when the FSM enters the
// matching phase and hold, with mem_addr and mem_wr_line stable, until the
// single-cycle mem_gnt pulse; mem_rd_line is taken in that gnt cycle.
module dcache_wb_lru #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int WAY_CNT       = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rd_req,
    input  logic                                wr_req,
    input  logic [31:0]                         addr,
    input  logic [31:0]                         wr_data,
    input  logic [3:0]                          wr_be,
    output logic [31:0]                         rd_data,
    output logic                                miss,
    output logic                                mem_rd_req,
    output logic                                mem_wr_req,
    output logic [32-2-LINE_ADDR_LEN-1:0]       mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]      mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]      mem_rd_line,
    input  logic                                mem_gnt
);

    localparam int TAG_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int SETS    = 1 << SET_ADDR_LEN;
    localparam int LINE_W  = 32 << LINE_ADDR_LEN;
    localparam int WAY_W   = $clog2(WAY_CNT);

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    typedef logic [WAY_CNT-1:0][WAY_W-1:0] age_vec_t;

    // Address fields; the byte offset within a word is not used.
    logic [LINE_ADDR_LEN-1:0] off_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_LEN-1:0]       tag_in;
    logic                     unused_addr_bits;
    assign off_idx          = addr[LINE_ADDR_LEN+1:2];
    assign set_idx          = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign tag_in           = addr[31 -: TAG_LEN];
    assign unused_addr_bits = ^addr[1:0];

    state_t                          state_q, state_d;
    logic [WAY_W-1:0]                victim_q, victim_d;
    logic [LINE_W-1:0]               fill_q, fill_d;
    logic [WAY_CNT-1:0]              valid_q [SETS];
    logic [WAY_CNT-1:0]              valid_d [SETS];
    logic [WAY_CNT-1:0]              dirty_q [SETS];
    logic [WAY_CNT-1:0]              dirty_d [SETS];
    logic [WAY_CNT-1:0][TAG_LEN-1:0] tag_q   [SETS];
    logic [WAY_CNT-1:0][TAG_LEN-1:0] tag_d   [SETS];
    age_vec_t                        age_q   [SETS];
    age_vec_t                        age_d   [SETS];
    logic [LINE_W-1:0]               data_q  [SETS][WAY_CNT];
    logic [LINE_W-1:0]               data_d  [SETS][WAY_CNT];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_sel;
    logic [LINE_W-1:0] wline;

    // Touched way becomes youngest; ways younger than its old age shift up one.
    function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [WAY_W-1:0] way);
        age_vec_t res;
        res = ages;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_W'(w) == way)
                res[w] = '0;
            else if (ages[w] < ages[way])
                res[w] = ages[w] + WAY_W'(1);
        end
        return res;
    endfunction

    // Tag match across the addressed set; lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way.
    always_comb begin
        victim_sel = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (age_q[set_idx][w] == WAY_W'(WAY_CNT - 1))
                victim_sel = WAY_W'(w);
        end
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w])
                victim_sel = WAY_W'(w);
        end
    end

    assign miss    = (state_q != IDLE) | ((rd_req | wr_req) & ~hit);
    assign rd_data = (state_q == IDLE && rd_req && hit)
                   ? data_q[set_idx][hit_way][32*int'(off_idx) +: 32] : 32'h0;

    // Next-state, array updates and memory-port outputs.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        fill_d      = fill_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        age_d       = age_q;
        data_d      = data_q;
        wline       = data_q[set_idx][hit_way];
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    if (hit) begin
                        age_d[set_idx] = lru_touch(age_q[set_idx], hit_way);
                        if (wr_req) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wr_be[b])
                                    wline[32*int'(off_idx) + 8*b +: 8] = wr_data[8*b +: 8];
                            end
                            data_d[set_idx][hit_way]  = wline;
                            dirty_d[set_idx][hit_way] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        if (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel])
                            state_d = SWAP_OUT;
                        else
                            state_d = SWAP_IN;
                    end
                end
            end
            SWAP_OUT: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {tag_q[set_idx][victim_q], set_idx};
                mem_wr_line = data_q[set_idx][victim_q];
                if (mem_gnt)
                    state_d = SWAP_IN;
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {tag_in, set_idx};
                if (mem_gnt) begin
                    fill_d  = mem_rd_line;
                    state_d = SWAP_IN_OK;
                end
            end
            SWAP_IN_OK: begin
                data_d[set_idx][victim_q]  = fill_q;
                tag_d[set_idx][victim_q]   = tag_in;
                valid_d[set_idx][victim_q] = 1'b1;
                dirty_d[set_idx][victim_q] = 1'b0;
                age_d[set_idx]             = lru_touch(age_q[set_idx], victim_q);
                state_d                    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and line metadata; ages reset to way index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                tag_q[s]   <= '0;
                for (int w = 0; w < WAY_CNT; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            age_q    <= age_d;
        end
    end

    // Data storage is not cleared; it is simply frozen while reset is held.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
        if (!rst)
            data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_wb_lru.sv
// Directed bench for dcache_wb_lru: cold fill, hits, byte-enable store,
// LRU victim choice, delayed dirty eviction, and reset during a refill.
module tb_dcache_wb_lru;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic         wr_req;
    logic [31:0]  addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic [31:0]  rd_data;
    logic         miss;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [26:0]  mem_addr;
    logic [255:0] mem_wr_line;
    logic [255:0] mem_rd_line;
    logic         mem_gnt;

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_line;
    logic [31:0]  tmp_word;

    dcache_wb_lru dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt)
    );

    always #5 clk = ~clk;

    // Main-memory contents: a distinct word per (line address, word index).
    function automatic logic [31:0] word_of(input logic [26:0] la, input int i);
        return 32'h8000_0000 | ({5'b0, la} << 4) | 32'(i);
    endfunction

    function automatic logic [255:0] line_of(input logic [26:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = word_of(la, i);
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a request at the falling edge, then settle before sampling.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        rd_req  = rd;
        wr_req  = wr;
        addr    = a;
        wr_data = d;
        wr_be   = be;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic gnt_pulse(input logic [255:0] l);
        mem_rd_line = l;
        mem_gnt     = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
    endtask

    // Clean-victim refill with immediate grant: exactly three stall cycles.
    task automatic fill_clean(input string tg, input logic [26:0] la);
        check({tg, "_miss_idle"}, {31'b0, miss}, 32'd1);
        check({tg, "_rdreq_idle"}, {31'b0, mem_rd_req}, 32'd0);
        tick();
        check({tg, "_miss_in"}, {31'b0, miss}, 32'd1);
        check({tg, "_rdreq_in"}, {31'b0, mem_rd_req}, 32'd1);
        check({tg, "_wrreq_in"}, {31'b0, mem_wr_req}, 32'd0);
        check({tg, "_addr_in"}, {5'b0, mem_addr}, {5'b0, la});
        gnt_pulse(line_of(la));
        tick();
        check({tg, "_miss_ok"}, {31'b0, miss}, 32'd1);
        check({tg, "_rdreq_ok"}, {31'b0, mem_rd_req}, 32'd0);
        tick();
        check({tg, "_miss_hit"}, {31'b0, miss}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        addr        = 32'h0;
        wr_data     = 32'h0;
        wr_be       = 4'h0;
        mem_rd_line = '0;
        mem_gnt     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_miss", {31'b0, miss}, 32'd0);
        check("rst_rdreq", {31'b0, mem_rd_req}, 32'd0);
        check("rst_wrreq", {31'b0, mem_wr_req}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_mem_addr", {5'b0, mem_addr}, 32'd0);
        rst = 1'b0;

        // Cold load from 0x100 (line address 8) into set 0.
        drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        fill_clean("cold", 27'd8);
        check("cold_rd_data", rd_data, word_of(27'd8, 0));

        // Same line, next word: immediate hit.
        drive(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        check("hit104_miss", {31'b0, miss}, 32'd0);
        check("hit104_data", rd_data, word_of(27'd8, 1));
        check("hit104_rdreq", {31'b0, mem_rd_req}, 32'd0);

        // Half-word store, then read it back.
        drive(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        check("st100_miss", {31'b0, miss}, 32'd0);
        check("st100_wrreq", {31'b0, mem_wr_req}, 32'd0);
        drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        tmp_word = word_of(27'd8, 0);
        check("ld100_miss", {31'b0, miss}, 32'd0);
        check("ld100_data", rd_data, {tmp_word[31:16], 16'hBEEF});

        // Fill the rest of set 0: B by store-allocate (dirty), C and D by loads.
        drive(1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF);
        fill_clean("fillb", 27'd16);
        drive(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        fill_clean("fillc", 27'd24);
        check("fillc_data", rd_data, word_of(27'd24, 0));
        drive(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        fill_clean("filld", 27'd32);

        // Touch A so B becomes the oldest way.
        drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        check("touch_a_miss", {31'b0, miss}, 32'd0);
        check("touch_a_data", rd_data, {tmp_word[31:16], 16'hBEEF});

        // Idle cycle with a stray grant: nothing happens.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        gnt_pulse(line_of(27'd99));
        tick();
        check("idle_miss", {31'b0, miss}, 32'd0);
        check("idle_rdreq", {31'b0, mem_rd_req}, 32'd0);
        check("idle_wrreq", {31'b0, mem_wr_req}, 32'd0);

        // Miss on E (0x500): B is dirty, written back with 5 cycles of grant delay.
        exp_line        = line_of(27'd16);
        exp_line[31:0]  = 32'h12345678;
        drive(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        check("ev_miss_idle", {31'b0, miss}, 32'd1);
        check("ev_wrreq_idle", {31'b0, mem_wr_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ev_out_miss", {31'b0, miss}, 32'd1);
            check("ev_out_wrreq", {31'b0, mem_wr_req}, 32'd1);
            check("ev_out_rdreq", {31'b0, mem_rd_req}, 32'd0);
            check("ev_out_addr", {5'b0, mem_addr}, 32'd16);
            check_line("ev_out_line", mem_wr_line, exp_line);
            if (k == 5)
                gnt_pulse(line_of(27'd40));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ev_in_miss", {31'b0, miss}, 32'd1);
            check("ev_in_rdreq", {31'b0, mem_rd_req}, 32'd1);
            check("ev_in_wrreq", {31'b0, mem_wr_req}, 32'd0);
            check("ev_in_addr", {5'b0, mem_addr}, 32'd40);
            if (k == 5)
                gnt_pulse(line_of(27'd40));
        end
        tick();
        check("ev_ok_miss", {31'b0, miss}, 32'd1);
        check("ev_ok_rdreq", {31'b0, mem_rd_req}, 32'd0);
        check("ev_ok_wrreq", {31'b0, mem_wr_req}, 32'd0);
        tick();
        check("ev_hit_miss", {31'b0, miss}, 32'd0);
        check("ev_hit_data", rd_data, word_of(27'd40, 0));

        // Load and store together: store wins, read shows the old word.
        drive(1'b1, 1'b1, 32'h500, 32'hCAFEF00D, 4'hF);
        check("rw_miss", {31'b0, miss}, 32'd0);
        check("rw_old_data", rd_data, word_of(27'd40, 0));
        drive(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        check("rw_new_data", rd_data, 32'hCAFEF00D);

        // 0x600 must evict clean C (oldest), so no writeback precedes the fetch.
        drive(1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        fill_clean("fill600", 27'd48);
        check("fill600_data", rd_data, word_of(27'd48, 0));

        // C was evicted: 0x300 misses; reset arrives while it is fetching.
        drive(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        check("c_gone_miss", {31'b0, miss}, 32'd1);
        tick();
        check("rst_in_rdreq", {31'b0, mem_rd_req}, 32'd1);
        check("rst_in_addr", {5'b0, mem_addr}, 32'd24);
        rst         = 1'b1;
        mem_gnt     = 1'b1;
        mem_rd_line = line_of(27'd24);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_gnt = 1'b0;
        rd_req  = 1'b0;
        #1;
        check("post_rst_rdreq", {31'b0, mem_rd_req}, 32'd0);
        check("post_rst_wrreq", {31'b0, mem_wr_req}, 32'd0);
        check("post_rst_miss", {31'b0, miss}, 32'd0);

        // Everything was invalidated: the same address refills from scratch.
        drive(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        fill_clean("reload", 27'd24);
        check("reload_data", rd_data, word_of(27'd24, 0));
        drive(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        check("e_gone_miss", {31'b0, miss}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_wb_lru.md
Name: dcache_wb_lru

Overview:
- Set-associative, write-back, write-allocate data cache with LRU replacement.
- Sits in the MEM stage of the pipelined RV32I core, serving load/store requests from the MEM/WB path.
- Raises `miss` to the hazard unit, which stalls the whole pipeline while the line is refilled.
- Talks to a line-wide main-memory port through a req/gnt handshake.

Parameters:
- LINE_ADDR_LEN, 3: log2 of words per line (default 8 words = 32 bytes).
- SET_ADDR_LEN, 2: log2 of set count (default 4 sets).
- WAY_CNT, 4: ways per set; power of two, at least 2.
- TAG_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (default 25); derived, not overridable.

Ports:
- clk  in  1  clock; every state update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  load request, held stable by the core while miss=1.
- wr_req  in  1  store request, held stable while miss=1.
- addr  in  32  byte address; [1:0] ignored; offset [LINE_ADDR_LEN+1:2], set next SET_ADDR_LEN bits, tag the rest.
- wr_data  in  32  store data.
- wr_be  in  4  byte enables for the store.
- rd_data  out  32  word read; valid when miss=0 and rd_req=1.
- miss  out  1  stall request to the hazard unit.
- mem_rd_req  out  1  line fetch request.
- mem_wr_req  out  1  line writeback request.
- mem_addr  out  32-2-LINE_ADDR_LEN  line address {tag,set}.
- mem_wr_line  out  32<<LINE_ADDR_LEN  victim line data.
- mem_rd_line  in  32<<LINE_ADDR_LEN  fetched line; valid in the mem_gnt cycle.
- mem_gnt  in  1  one-cycle completion pulse for the outstanding request.

Behaviour:
- Per-line storage: valid, dirty, tag, data; per way a log2(WAY_CNT)-bit age.
- Reset values:
  - Every valid and dirty bit is 0; the age of way w is w.
  - State is IDLE; miss, mem_rd_req, mem_wr_req and rd_data are 0; mem_addr is 0.
  - Data arrays are not reset.
- Hit and miss evaluation:
  - hit = some way in addr's set is valid with a matching tag; evaluated combinationally in IDLE.
  - miss = (state != IDLE) | ((rd_req|wr_req) & !hit). It is combinational and has no registered latency.
- Read hit: rd_data is the selected word combinationally in the same cycle, with zero wait.
- Write hit: the enabled bytes are written and dirty is set at the next edge. If rd_req and wr_req are both high, the write wins and rd_data still shows the pre-write word.
- LRU update on every hit, at the edge, and on every fill:
  - The accessed way's age becomes 0.
  - Each way whose age is less than the accessed way's old age increments.
  - The ages in a set remain a permutation of 0..WAY_CNT-1.
- Victim selection: the lowest-index invalid way first; otherwise the way with age WAY_CNT-1. It is latched on leaving IDLE.
- State machine, entered from IDLE on a request that misses:
  - IDLE -> SWAP_OUT if the victim is valid and dirty; otherwise IDLE -> SWAP_IN.
  - SWAP_OUT:
    - Drives mem_wr_req=1, mem_addr={victim tag,set} and mem_wr_line=victim data.
    - Holds until mem_gnt, then goes to SWAP_IN.
  - SWAP_IN:
    - Drives mem_rd_req=1 and mem_addr={addr tag,set}.
    - Holds until mem_gnt, latching mem_rd_line, then goes to SWAP_IN_OK.
  - SWAP_IN_OK (one cycle):
    - Writes the line, tag, valid=1 and dirty=0 into the victim way and updates LRU.
    - Goes to IDLE. miss is still 1 in this cycle.
  - In the following IDLE cycle the request hits (miss=0); a store completes then as a write hit.
- Handshake:
  - mem_rd_req and mem_wr_req are never high together.
  - mem_addr and mem_wr_line are stable from request rise until mem_gnt.
  - mem_gnt outside SWAP_OUT/SWAP_IN is ignored.
  - Minimum miss penalty with mem_gnt in the first request cycle: clean victim, 3 stall cycles; dirty victim, 4.
- Reset mid-operation:
  - State returns to IDLE and the requests drop at the next edge.
  - A latched fill is discarded and no array is written.
- With no request (rd_req=wr_req=0): no LRU change, miss=0 in IDLE.

Test Plan:
- Cold load from 0x100, mem_gnt one cycle after request:
  - mem_rd_req rises with mem_addr=0x100>>5 and miss=1 for 3 cycles.
  - Then rd_data equals word 0 of the supplied line with miss=0.
- Load 0x104 after the above:
  - miss=0 in the same cycle.
  - rd_data = word 1, with no mem request.
- Store 0xDEADBEEF with wr_be=4'b0011 to 0x100, then load 0x100:
  - miss=0 on both.
  - rd_data = {old[31:16],16'hBEEF}; dirty set.
- Fill set 0 with tags A,B,C,D (same set index), touch A, then miss on tag E:
  - The victim is B.
  - If B is dirty, mem_wr_req fires with B's address and data before mem_rd_req.
- Dirty eviction with mem_gnt delayed 5 cycles on each phase:
  - Requests stay stable; miss stays 1 throughout.
  - Exactly one write then one read is issued.
- Assert rst during SWAP_IN, then release:
  - Next cycle state is IDLE with mem_rd_req=0.
  - All lines are invalid, so a reload of the same address misses again.
